row_stream_reader: RTL and testbench

ROW_STREAM_READER -- requirements
Module: row_stream_reader

---
 rtl/row_stream_reader.sv | 119 +++++++++++
 tb/tb_row_stream_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_stream_reader.sv
// Row store that streams every stored row to a ready/valid consumer on request.
// Each row is snapshotted into an output register in LOAD and held through SEND.
module row_stream_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             writeenable,
    input  logic [4:0]       writeAddr,
    input  logic [WIDTH-1:0] writeIn,
    input  logic             start,
    input  logic             rowReady,
    output logic [WIDTH-1:0] rowOut,
    output logic [4:0]       rowIndex,
    output logic             rowValid,
    output logic             busy,
    output logic             frameDone
);

    localparam int unsigned IW = 5;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic [IW-1:0]    rowidx_q, rowidx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_c;

    // Row read mux; addresses at or beyond DEPTH never match.
    always_comb begin
        rd_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (idx_q == IW'(i)) begin
                rd_c = mem_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        row_d    = row_q;
        rowidx_d = rowidx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A write landing on the row being loaded wins over the stale stored value.
                row_d    = (writeenable && (writeAddr == idx_q)) ? writeIn : rd_c;
                rowidx_d = idx_q;
                state_d  = SEND;
            end
            SEND: begin
                if (rowReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            row_q    <= '0;
            rowidx_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            rowidx_q <= rowidx_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (writeenable) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (writeAddr == IW'(i)) begin
                    mem_q[i] <= writeIn;
                end
            end
        end
    end

    assign rowOut    = row_q;
    assign rowIndex  = rowidx_q;
    assign rowValid  = (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign frameDone = (state_q == DONE);

endmodule

// File: tb/tb_row_stream_reader.sv
// Scoreboard bench for row_stream_reader: default DEPTH=20 instance plus a DEPTH=2 instance.
module tb_row_stream_reader;

    localparam int unsigned D = 20;
    localparam int unsigned W = 32;

    logic          clock, reset;
    logic          writeenable, start, rowReady;
    logic [4:0]    writeAddr;
    logic [W-1:0]  writeIn;
    logic [W-1:0]  rowOut;
    logic [4:0]    rowIndex;
    logic          rowValid, busy, frameDone;

    logic          d2_we, d2_start, d2_ready;
    logic [4:0]    d2_addr;
    logic [W-1:0]  d2_in;
    logic [W-1:0]  d2_out;
    logic [4:0]    d2_idx;
    logic          d2_valid, d2_busy, d2_done;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  mem_m [D];
    logic [36:0]   exp_q [$];

    row_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .writeenable(writeenable), .writeAddr(writeAddr),
        .writeIn(writeIn), .start(start), .rowReady(rowReady), .rowOut(rowOut),
        .rowIndex(rowIndex), .rowValid(rowValid), .busy(busy), .frameDone(frameDone)
    );

    row_stream_reader #(.WIDTH(W), .DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .writeenable(d2_we), .writeAddr(d2_addr),
        .writeIn(d2_in), .start(d2_start), .rowReady(d2_ready), .rowOut(d2_out),
        .rowIndex(d2_idx), .rowValid(d2_valid), .busy(d2_busy), .frameDone(d2_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic write_row(input logic [4:0] a, input logic [W-1:0] d);
        writeenable = 1'b1;
        writeAddr   = a;
        writeIn     = d;
        @(negedge clock);
        writeenable = 1'b0;
        if (32'(a) < D) mem_m[a] = d;
    endtask

    // Drives one start and follows the scan to IDLE; -1 disables an optional event.
    task automatic run_scan(input string name, input int stall_row, input int stall_n,
                            input int byp_row, input logic [W-1:0] byp_val,
                            input int snap_row, input logic [W-1:0] snap_val,
                            input int restart_row);
        int cyc, done_cnt, done_cyc, stall_cnt, extra;
        bit new_row, snap_done;
        logic [W-1:0] hold_out;
        logic [4:0]   hold_idx, load_row;
        logic [36:0]  e;
        exp_q.delete();
        for (int i = 0; i < int'(D); i++)
            exp_q.push_back({5'(i), (i == byp_row) ? byp_val : mem_m[i]});
        cyc = 1; done_cnt = 0; done_cyc = 0; stall_cnt = 0; extra = 0;
        new_row = 1'b1; snap_done = 1'b0; load_row = '0;
        hold_out = '0; hold_idx = '0;
        start = 1'b1; rowReady = 1'b1;
        while (cyc < 400) begin
            @(negedge clock);
            cyc++;
            start = 1'b0; writeenable = 1'b0; rowReady = 1'b1;
            if (frameDone) begin
                done_cnt++;
                done_cyc = cyc;
            end else if (!busy) begin
                break;
            end else if (!rowValid) begin
                if (int'(load_row) == byp_row) begin
                    writeenable = 1'b1; writeAddr = load_row; writeIn = byp_val;
                    mem_m[load_row] = byp_val;
                end
            end else begin
                if (new_row) begin
                    hold_out = rowOut; hold_idx = rowIndex; new_row = 1'b0;
                end else begin
                    n_checks++;
                    if (rowOut !== hold_out || rowIndex !== hold_idx) begin
                        n_fail++;
                        $display("FAIL %s hold: idx=%0d out=%h, required idx=%0d out=%h",
                                 name, rowIndex, rowOut, hold_idx, hold_out);
                    end
                end
                if (int'(rowIndex) == stall_row && stall_cnt < stall_n) begin
                    rowReady = 1'b0; stall_cnt++; extra++;
                end else if (int'(rowIndex) == snap_row && !snap_done) begin
                    rowReady = 1'b0; snap_done = 1'b1; extra++;
                    writeenable = 1'b1; writeAddr = rowIndex; writeIn = snap_val;
                    mem_m[rowIndex] = snap_val;
                end else begin
                    if (int'(rowIndex) == restart_row) begin
                        start = 1'b1; writeenable = 1'b1; writeAddr = 5'd25; writeIn = 32'hFFFF_FFFF;
                    end
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra row: idx=%0d out=%h, required none", name, rowIndex, rowOut);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rowIndex, rowOut} !== e) begin
                            n_fail++;
                            $display("FAIL %s row: idx=%0d out=%h, required idx=%0d out=%h",
                                     name, rowIndex, rowOut, e[36:32], e[31:0]);
                        end
                    end
                    new_row = 1'b1;
                    load_row = rowIndex + 5'd1;
                end
            end
        end
        n_checks++;
        if (cyc >= 400) begin
            n_fail++;
            $display("FAIL %s timeout: cycles=%0d, required < 400", name, cyc);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s frameDone count: %0d, required 1", name, done_cnt);
        end
        n_checks++;
        if (done_cyc != int'(2 * D + 2) + extra) begin
            n_fail++;
            $display("FAIL %s frameDone cycle: %0d, required %0d", name, done_cyc, int'(2 * D + 2) + extra);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s rows missing: %0d, required 0", name, exp_q.size());
        end
        n_checks++;
        if (busy !== 1'b0 || rowValid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after: busy=%b valid=%b, required 0 0", name, busy, rowValid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({rowOut, rowIndex} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset data: idx=%0d out=%h, required 0 0", rowIndex, rowOut);
        end
        n_checks++;
        if ({rowValid, busy, frameDone} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset flags: %b, required 000", {rowValid, busy, frameDone});
        end
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || d2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset hold: busy=%b d2_busy=%b, required 0 0", busy, d2_busy);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_full_scan();
        for (int i = 0; i < int'(D); i++) write_row(5'(i), 32'hA000_0000 + 32'(i));
        run_scan("full_scan", -1, 0, -1, '0, -1, '0, -1);
    endtask

    task automatic test_stall();
        run_scan("stall", 5, 3, -1, '0, -1, '0, -1);
    endtask

    task automatic test_bypass_snapshot();
        run_scan("bypass_snap", -1, 0, 7, 32'h1234_5678, 8, 32'hDEAD_BEEF, -1);
    endtask

    task automatic test_restart_ignored();
        run_scan("restart", -1, 0, -1, '0, -1, '0, 10);
    endtask

    task automatic test_storage_after();
        run_scan("storage", -1, 0, -1, '0, -1, '0, -1);
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        found = 1'b0;
        start = 1'b1; rowReady = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (rowValid && rowIndex == 5'd12) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid reach row 12: found=%0d, required 1", found);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({rowOut, rowIndex} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid data: idx=%0d out=%h, required 0 0", rowIndex, rowOut);
        end
        n_checks++;
        if ({rowValid, busy, frameDone} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid flags: %b, required 000", {rowValid, busy, frameDone});
        end
        @(negedge clock);
        n_checks++;
        if (frameDone !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid held: done=%b busy=%b, required 0 0", frameDone, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < int'(D); i++) mem_m[i] = '0;
        @(negedge clock);
        run_scan("post_reset", -1, 0, -1, '0, -1, '0, -1);
    endtask

    task automatic test_depth2();
        logic [36:0] q2 [$];
        logic [36:0] e;
        int cyc, done_cnt, done_cyc;
        d2_we = 1'b1; d2_addr = 5'd0; d2_in = 32'h0000_1111;
        @(negedge clock);
        d2_addr = 5'd1; d2_in = 32'h0000_2222;
        @(negedge clock);
        d2_addr = 5'd2; d2_in = 32'h0000_0BAD;
        @(negedge clock);
        d2_we = 1'b0;
        q2.push_back({5'd0, 32'h0000_1111});
        q2.push_back({5'd1, 32'h0000_2222});
        cyc = 1; done_cnt = 0; done_cyc = 0;
        d2_start = 1'b1; d2_ready = 1'b1;
        while (cyc < 30) begin
            @(negedge clock);
            cyc++;
            d2_start = 1'b0;
            if (d2_done) begin
                done_cnt++; done_cyc = cyc;
            end else if (!d2_busy) begin
                break;
            end else if (d2_valid) begin
                n_checks++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL depth2 extra row: idx=%0d, required none", d2_idx);
                end else begin
                    e = q2.pop_front();
                    if ({d2_idx, d2_out} !== e) begin
                        n_fail++;
                        $display("FAIL depth2 row: idx=%0d out=%h, required idx=%0d out=%h",
                                 d2_idx, d2_out, e[36:32], e[31:0]);
                    end
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 6) begin
            n_fail++;
            $display("FAIL depth2 frameDone: count=%0d cycle=%0d, required 1 6", done_cnt, done_cyc);
        end
        n_checks++;
        if (q2.size() != 0 || d2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL depth2 end: left=%0d busy=%b, required 0 0", q2.size(), d2_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        writeenable = 1'b0; writeAddr = '0; writeIn = '0; start = 1'b0; rowReady = 1'b0;
        d2_we = 1'b0; d2_addr = '0; d2_in = '0; d2_start = 1'b0; d2_ready = 1'b0;
        for (int i = 0; i < int'(D); i++) mem_m[i] = '0;
        test_reset();
        test_full_scan();
        test_stall();
        test_bypass_snapshot();
        test_restart_ignored();
        test_storage_after();
        test_reset_mid_scan();
        test_depth2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
